// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Shares the register file's single write port between two writeback
// requesters (req0 = ALU/execute, req1 = load/memory). One real write is
// granted per cycle and staged in a registered output stage that drives
// the regFile write port. The staged write is forwarded to both decode
// read ports until it commits.
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   hold                      freeze arbitration (no grants, no x0 acks)
//   reqN_valid/addr/data      requester N write request (N = 0, 1)
//   reqN_ready                requester N accepted this cycle (combinational)
//   we, wb_addr, wb_data      registered regFile write port
//   rsN_addr                  decode read addresses (N = 1, 2)
//   rsN_fwd_valid/data        take forwarded data instead of regFile data
//
// Parameters:
//   ARB_MODE     0 = round-robin, 1 = fixed priority (req0) with starvation guard
//   STARVE_LIMIT consecutive req1 losses that force one req1 grant (1..15)
module regfile_wb_arbiter #(
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 32,
  parameter int ARB_MODE     = 0,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              hold,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              we,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic              rs1_fwd_valid,
  output logic [DATA_W-1:0] rs1_fwd_data,
  output logic              rs2_fwd_valid,
  output logic [DATA_W-1:0] rs2_fwd_data
);

  localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

  logic              r_we;
  logic [ADDR_W-1:0] r_wb_addr;
  logic [DATA_W-1:0] r_wb_data;
  logic              r_prio;
  logic [3:0]        r_starve_cnt;

  logic w_open;
  logic w_zero0;
  logic w_zero1;
  logic w_real0;
  logic w_real1;
  logic w_pick1;
  logic w_grant0;
  logic w_grant1;

  assign w_open  = reset_n & ~hold;
  assign w_zero0 = (req0_addr == '0);
  assign w_zero1 = (req1_addr == '0);
  assign w_real0 = req0_valid & ~w_zero0;
  assign w_real1 = req1_valid & ~w_zero1;

  // Contention winner when both ports carry a real write: 1 means req1.
  assign w_pick1 = (ARB_MODE == 0) ? r_prio : (r_starve_cnt == LP_LIMIT);

  // A port is ready when it targets x0 (ack-and-drop), when the other port
  // is not competing, or when it wins contention. The port's own valid is
  // never looked at, so ready cannot loop back on valid.
  assign req0_ready = w_open & (w_zero0 | ~w_real1 | ~w_pick1);
  assign req1_ready = w_open & (w_zero1 | ~w_real0 |  w_pick1);

  assign w_grant0 = w_real0 & req0_ready;
  assign w_grant1 = w_real1 & req1_ready;

  // Output stage plus arbitration history. A losing req1 only counts as
  // starved when req0 actually took the port; hold leaves history untouched
  // because neither grant can fire.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_we         <= 1'b0;
      r_wb_addr    <= '0;
      r_wb_data    <= '0;
      r_prio       <= 1'b0;
      r_starve_cnt <= '0;
    end else begin
      r_we <= w_grant0 | w_grant1;
      if (w_grant0) begin
        r_wb_addr <= req0_addr;
        r_wb_data <= req0_data;
        r_prio    <= 1'b1;
      end else if (w_grant1) begin
        r_wb_addr <= req1_addr;
        r_wb_data <= req1_data;
        r_prio    <= 1'b0;
      end
      if (w_grant1) begin
        r_starve_cnt <= '0;
      end else if (w_real1 && w_grant0 && (r_starve_cnt != LP_LIMIT)) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
    end
  end

  assign we      = r_we;
  assign wb_addr = r_wb_addr;
  assign wb_data = r_wb_data;

  // Only the staged write is forwarded; x0 never forwards since it reads 0.
  assign rs1_fwd_valid = r_we & (rs1_addr == r_wb_addr) & (rs1_addr != '0);
  assign rs2_fwd_valid = r_we & (rs2_addr == r_wb_addr) & (rs2_addr != '0);
  assign rs1_fwd_data  = rs1_fwd_valid ? r_wb_data : '0;
  assign rs2_fwd_data  = rs2_fwd_valid ? r_wb_data : '0;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
// Drives a round-robin instance (u_rr) and a fixed-priority instance (u_fp)
// from the same inputs. Directed tasks cover reset, contention, starvation,
// x0 writes, forwarding, hold and asynchronous reset; a randomized task
// compares both instances against a cycle-level behavioural model.
module tb_regfile_wb_arbiter;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          hold;
  logic          v0, v1;
  logic [AW-1:0] a0, a1, rs1, rs2;
  logic [DW-1:0] d0, d1;

  logic [1:0]    rdy0, rdy1, weO, f1v, f2v;
  logic [AW-1:0] wbA [2];
  logic [DW-1:0] wbD [2];
  logic [DW-1:0] f1d [2];
  logic [DW-1:0] f2d [2];

  int checks = 0;
  int errors = 0;

  // Model state per instance (0 = round-robin, 1 = fixed priority).
  int            mFav  [2];
  int            mLoss [2];
  logic          mWe   [2];
  logic [AW-1:0] mAddr [2];
  logic [DW-1:0] mData [2];

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0), .STARVE_LIMIT(LIMIT)) u_rr (
    .clk(clk), .reset_n(reset_n), .hold(hold),
    .req0_valid(v0), .req0_ready(rdy0[0]), .req0_addr(a0), .req0_data(d0),
    .req1_valid(v1), .req1_ready(rdy1[0]), .req1_addr(a1), .req1_data(d1),
    .we(weO[0]), .wb_addr(wbA[0]), .wb_data(wbD[0]),
    .rs1_addr(rs1), .rs2_addr(rs2),
    .rs1_fwd_valid(f1v[0]), .rs1_fwd_data(f1d[0]),
    .rs2_fwd_valid(f2v[0]), .rs2_fwd_data(f2d[0]));

  regfile_wb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1), .STARVE_LIMIT(LIMIT)) u_fp (
    .clk(clk), .reset_n(reset_n), .hold(hold),
    .req0_valid(v0), .req0_ready(rdy0[1]), .req0_addr(a0), .req0_data(d0),
    .req1_valid(v1), .req1_ready(rdy1[1]), .req1_addr(a1), .req1_data(d1),
    .we(weO[1]), .wb_addr(wbA[1]), .wb_data(wbD[1]),
    .rs1_addr(rs1), .rs2_addr(rs2),
    .rs1_fwd_valid(f1v[1]), .rs1_fwd_data(f1d[1]),
    .rs2_fwd_valid(f2v[1]), .rs2_fwd_data(f2d[1]));

  // Clears the inputs, pulses reset across a clock edge and resets the model.
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    hold = 1'b0; v0 = 1'b0; v1 = 1'b0;
    a0 = '0; a1 = '0; d0 = '0; d1 = '0; rs1 = '0; rs2 = '0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int m = 0; m < 2; m++) begin
      mFav[m] = 0; mLoss[m] = 0; mWe[m] = 1'b0; mAddr[m] = '0; mData[m] = '0;
    end
  endtask

  // Which port the model expects to win when both carry a real write.
  function automatic int model_winner(int m);
    if (m == 0) return mFav[m];
    return (mLoss[m] >= LIMIT) ? 1 : 0;
  endfunction

  // Expected {ready1, ready0} for the current inputs (meaningful when valid).
  function automatic logic [1:0] model_ready(int m);
    logic real0, real1, r0, r1;
    if (!reset_n || hold) return 2'b00;
    real0 = v0 && (a0 != 0);
    real1 = v1 && (a1 != 0);
    r0 = (a0 == 0) || !real1 || (model_winner(m) == 0);
    r1 = (a1 == 0) || !real0 || (model_winner(m) == 1);
    return {r1, r0};
  endfunction

  // Advances the model across one rising edge.
  task automatic model_commit(int m);
    logic [1:0] r;
    logic g0, g1;
    r  = model_ready(m);
    g0 = v0 && r[0] && (a0 != 0);
    g1 = v1 && r[1] && (a1 != 0);
    mWe[m] = g0 || g1;
    if (g0) begin
      mAddr[m] = a0; mData[m] = d0; mFav[m] = 1;
    end else if (g1) begin
      mAddr[m] = a1; mData[m] = d1; mFav[m] = 0;
    end
    if (g1) mLoss[m] = 0;
    else if (v1 && (a1 != 0) && g0 && mLoss[m] < LIMIT) mLoss[m]++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0;
    v0 = 1'b1; a0 = 5'd5; d0 = 32'h1111_1111;
    v1 = 1'b1; a1 = 5'd7; d1 = 32'h2222_2222;
    #1;
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (weO[m] !== 1'b0 || rdy0[m] !== 1'b0 || rdy1[m] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_hold inst%0d: we=%b r0=%b r1=%b, required 0 0 0", m, weO[m], rdy0[m], rdy1[m]);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    v1 = 1'b0; d0 = 32'hA5A5_A5A5;
    #1;
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (rdy0[m] !== 1'b1) begin
        errors++;
        $display("[TB] FAIL reset_first_ready inst%0d: got %b, required 1", m, rdy0[m]);
      end
    end
    @(negedge clk);
    v0 = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (weO[m] !== 1'b1 || wbA[m] !== 5'd5 || wbD[m] !== 32'hA5A5_A5A5) begin
        errors++;
        $display("[TB] FAIL reset_first_write inst%0d: we=%b addr=%0d data=%h, required 1 5 a5a5a5a5", m, weO[m], wbA[m], wbD[m]);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [AW-1:0] lastAddr;
    do_reset();
    lastAddr = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      v0 = (i < 4); a0 = 5'd3; d0 = 32'h0000_0300 + i;
      v1 = (i < 4); a1 = 5'd7; d1 = 32'h0000_0700 + i;
      #1;
      if (i > 0) begin
        checks++;
        if (weO[0] !== 1'b1 || wbA[0] !== lastAddr) begin
          errors++;
          $display("[TB] FAIL rr_wb_addr step%0d: we=%b addr=%0d, required 1 %0d", i, weO[0], wbA[0], lastAddr);
        end
      end
      if (i < 4) begin
        checks++;
        if (rdy0[0] !== (i % 2 == 0) || rdy1[0] !== (i % 2 == 1)) begin
          errors++;
          $display("[TB] FAIL rr_grant step%0d: r0=%b r1=%b, required %b %b", i, rdy0[0], rdy1[0], (i % 2 == 0), (i % 2 == 1));
        end
        lastAddr = (i % 2 == 0) ? 5'd3 : 5'd7;
      end
    end
  endtask

  task automatic test_starvation();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      v0 = 1'b1; a0 = 5'd2; d0 = 32'h0000_00A0 + i;
      v1 = 1'b1; a1 = 5'd4; d1 = 32'h0000_00B0 + i;
      #1;
      checks++;
      if (rdy1[1] !== (i == 4) || rdy0[1] !== (i != 4)) begin
        errors++;
        $display("[TB] FAIL starve_grant step%0d: r0=%b r1=%b, required %b %b", i, rdy0[1], rdy1[1], (i != 4), (i == 4));
      end
    end
    @(negedge clk);
    v0 = 1'b0; v1 = 1'b0;
  endtask

  task automatic test_x0();
    do_reset();
    @(negedge clk);
    v0 = 1'b1; a0 = 5'd0; d0 = 32'hFFFF_FFFF;
    v1 = 1'b1; a1 = 5'd9; d1 = 32'h0000_0001;
    #1;
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (rdy0[m] !== 1'b1 || rdy1[m] !== 1'b1) begin
        errors++;
        $display("[TB] FAIL x0_both_ready inst%0d: r0=%b r1=%b, required 1 1", m, rdy0[m], rdy1[m]);
      end
    end
    @(negedge clk);
    v1 = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (weO[m] !== 1'b1 || wbA[m] !== 5'd9 || wbD[m] !== 32'h1 || rdy0[m] !== 1'b1) begin
        errors++;
        $display("[TB] FAIL x0_pair_write inst%0d: we=%b addr=%0d data=%h r0=%b, required 1 9 1 1", m, weO[m], wbA[m], wbD[m], rdy0[m]);
      end
    end
    @(negedge clk);
    v0 = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (weO[m] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL x0_alone_no_write inst%0d: we=%b, required 0", m, weO[m]);
      end
    end
  endtask

  task automatic test_forwarding();
    do_reset();
    @(negedge clk);
    v0 = 1'b1; a0 = 5'd12; d0 = 32'hDEAD_BEEF;
    rs1 = 5'd12; rs2 = 5'd0;
    #1;
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (f1v[m] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL fwd_same_cycle inst%0d: valid=%b, required 0", m, f1v[m]);
      end
    end
    @(negedge clk);
    v0 = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (f1v[m] !== 1'b1 || f1d[m] !== 32'hDEAD_BEEF || f2v[m] !== 1'b0 || f2d[m] !== 32'h0) begin
        errors++;
        $display("[TB] FAIL fwd_staged inst%0d: rs1 %b/%h rs2 %b/%h, required 1/deadbeef 0/0", m, f1v[m], f1d[m], f2v[m], f2d[m]);
      end
    end
  endtask

  task automatic test_hold_and_async_reset();
    do_reset();
    @(negedge clk);
    hold = 1'b1;
    v0 = 1'b1; a0 = 5'd4; d0 = 32'h4;
    v1 = 1'b1; a1 = 5'd0; d1 = 32'h6;
    #1;
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (rdy0[m] !== 1'b0 || rdy1[m] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL hold_ready inst%0d: r0=%b r1=%b, required 0 0", m, rdy0[m], rdy1[m]);
      end
    end
    @(negedge clk);
    hold = 1'b0; v1 = 1'b0; a0 = 5'd10; d0 = 32'h0BAD_F00D; rs1 = 5'd10;
    #1;
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (weO[m] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL hold_no_write inst%0d: we=%b, required 0", m, weO[m]);
      end
    end
    @(negedge clk);
    v0 = 1'b0;
    #1;
    checks++;
    if (weO[0] !== 1'b1 || f1v[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pre_reset_write: we=%b fwd=%b, required 1 1", weO[0], f1v[0]);
    end
    #2 reset_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (weO[m] !== 1'b0 || f1v[m] !== 1'b0 || f1d[m] !== 32'h0) begin
        errors++;
        $display("[TB] FAIL async_reset inst%0d: we=%b fwd=%b/%h, required 0 0/0", m, weO[m], f1v[m], f1d[m]);
      end
    end
    do_reset();
  endtask

  task automatic test_random();
    logic [1:0] r;
    logic [DW-1:0] e1, e2;
    logic ev1, ev2;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      hold = ($urandom_range(0, 9) == 0);
      v0 = ($urandom_range(0, 3) != 0); a0 = AW'($urandom_range(0, 7)); d0 = $urandom;
      v1 = ($urandom_range(0, 3) != 0); a1 = AW'($urandom_range(0, 7)); d1 = $urandom;
      rs1 = AW'($urandom_range(0, 7)); rs2 = AW'($urandom_range(0, 7));
      #1;
      for (int m = 0; m < 2; m++) begin
        r   = model_ready(m);
        ev1 = mWe[m] && (rs1 == mAddr[m]) && (rs1 != 0);
        ev2 = mWe[m] && (rs2 == mAddr[m]) && (rs2 != 0);
        e1  = ev1 ? mData[m] : '0;
        e2  = ev2 ? mData[m] : '0;
        checks++;
        if ((v0 && rdy0[m] !== r[0]) || (v1 && rdy1[m] !== r[1])) begin
          errors++;
          $display("[TB] FAIL rand_ready inst%0d cyc%0d: r0=%b r1=%b, required %b %b", m, c, rdy0[m], rdy1[m], r[0], r[1]);
        end
        checks++;
        if (weO[m] !== mWe[m] || wbA[m] !== mAddr[m] || wbD[m] !== mData[m]) begin
          errors++;
          $display("[TB] FAIL rand_stage inst%0d cyc%0d: %b/%0d/%h, required %b/%0d/%h", m, c, weO[m], wbA[m], wbD[m], mWe[m], mAddr[m], mData[m]);
        end
        checks++;
        if (f1v[m] !== ev1 || f1d[m] !== e1 || f2v[m] !== ev2 || f2d[m] !== e2) begin
          errors++;
          $display("[TB] FAIL rand_fwd inst%0d cyc%0d: %b/%h %b/%h, required %b/%h %b/%h", m, c, f1v[m], f1d[m], f2v[m], f2d[m], ev1, e1, ev2, e2);
        end
      end
      model_commit(0);
      model_commit(1);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    hold = 1'b0; v0 = 1'b0; v1 = 1'b0;
    a0 = '0; a1 = '0; d0 = '0; d1 = '0; rs1 = '0; rs2 = '0;
    test_reset();
    test_round_robin();
    test_starvation();
    test_x0();
    test_forwarding();
    test_hold_and_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
